// File: rtl/led_output_driver.sv
// ----------------------------------------------------------------------------
// led_output_driver
//
// Last stage between the LED controller and the front-panel LED pins.
// The logical LED vector is registered, then optionally pulse-stretched so
// single-cycle flashes stay visible. Global PWM dimming is applied next, and
// the board output polarity last of all. An on-demand lamp-test sequence can
// temporarily take over the pins. The sequence is all on, then a one-hot
// sweep, then all off.
//
// Ports:
//   clock             in   1          fabric clock (40 MHz)
//   reset_n           in   1          synchronous reset, active-low
//   led_i             in   NLEDS      logical LED state (1 = lit)
//   stretch_en_i      in   1          1 = enable per-channel pulse stretcher
//   brightness_i      in   PWM_BITS   global duty = (brightness_i+1)/2^PWM_BITS
//   lamp_test_i       in   1          single-cycle pulse starts the lamp test
//   invert_i          in   1          1 = LEDs are active-low on the board
//   lamp_test_busy_o  out  1          high while the lamp test runs
//   led_o             out  NLEDS      registered physical LED pin drive
// ----------------------------------------------------------------------------
module led_output_driver #(
   parameter int NLEDS            = 16,
   parameter int STRETCH_CYCLES   = 4000000,
   parameter int PWM_BITS         = 4,
   parameter int LAMP_STEP_CYCLES = 8000000
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [NLEDS-1:0]    led_i,
   input  logic                stretch_en_i,
   input  logic [PWM_BITS-1:0] brightness_i,
   input  logic                lamp_test_i,
   input  logic                invert_i,
   output logic                lamp_test_busy_o,
   output logic [NLEDS-1:0]    led_o
);

   localparam int CNT_W  = $clog2(STRETCH_CYCLES + 1);
   localparam int STEP_W = $clog2(LAMP_STEP_CYCLES + 1);

   localparam logic [CNT_W-1:0]    STRETCH_LOAD = CNT_W'(STRETCH_CYCLES);
   localparam logic [STEP_W-1:0]   STEP_LOAD    = STEP_W'(LAMP_STEP_CYCLES - 1);
   localparam logic [PWM_BITS-1:0] PWM_MAX      = '1;

   typedef enum logic [1:0] {
      IDLE,
      ALL_ON,
      SWEEP,
      ALL_OFF
   } lamp_state_t;

   logic [NLEDS-1:0]    led_q;
   logic [CNT_W-1:0]    cnt [NLEDS];
   logic [NLEDS-1:0]    str;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic [PWM_BITS-1:0] bright_q;
   logic                pwm_on;
   lamp_state_t         lamp_state;
   logic [STEP_W-1:0]   step_cnt;
   logic [NLEDS-1:0]    lamp_pat;

   // Input register: the first of the two pipeline stages.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         led_q <= '0;
      end else begin
         led_q <= led_i;
      end
   end

   // Per-channel hold counters. A lit input reloads the full hold, so a
   // re-pulse during the hold restarts it. Disabling the stretcher clears
   // every counter, so re-enabling it never shows a stale hold.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         for (int i = 0; i < NLEDS; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NLEDS; i++) begin
            if (!stretch_en_i) begin
               cnt[i] <= '0;
            end else if (led_q[i]) begin
               cnt[i] <= STRETCH_LOAD;
            end else if (cnt[i] != '0) begin
               cnt[i] <= cnt[i] - CNT_W'(1);
            end
         end
      end
   end

   // A channel is shown lit while its input is high or its hold is running.
   always_comb begin
      str = led_q;
      if (stretch_en_i) begin
         for (int i = 0; i < NLEDS; i++) begin
            if (cnt[i] != '0) begin
               str[i] = 1'b1;
            end
         end
      end
   end

   // Free-running PWM counter. Brightness is only taken at the last count
   // of a period, so a change never produces a short or long glitch pulse.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         pwm_cnt  <= '0;
         bright_q <= '1;
      end else begin
         pwm_cnt <= pwm_cnt + PWM_BITS'(1);
         if (pwm_cnt == PWM_MAX) begin
            bright_q <= brightness_i;
         end
      end
   end

   assign pwm_on = (pwm_cnt <= bright_q);

   // Lamp-test sequencer. step_cnt counts down to zero for each step, and
   // the sweep ends once the one-hot pattern has reached the top channel.
   // lamp_test_i only matters in IDLE, so extra pulses during a run are
   // ignored.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         lamp_state       <= IDLE;
         step_cnt         <= '0;
         lamp_pat         <= '0;
         lamp_test_busy_o <= 1'b0;
      end else begin
         case (lamp_state)
            IDLE: begin
               if (lamp_test_i) begin
                  lamp_state       <= ALL_ON;
                  step_cnt         <= STEP_LOAD;
                  lamp_pat         <= '1;
                  lamp_test_busy_o <= 1'b1;
               end else begin
                  lamp_test_busy_o <= 1'b0;
               end
            end
            ALL_ON: begin
               if (step_cnt == '0) begin
                  lamp_state <= SWEEP;
                  step_cnt   <= STEP_LOAD;
                  lamp_pat   <= NLEDS'(1);
               end else begin
                  step_cnt <= step_cnt - STEP_W'(1);
               end
            end
            SWEEP: begin
               if (step_cnt == '0) begin
                  step_cnt <= STEP_LOAD;
                  if (lamp_pat[NLEDS-1]) begin
                     lamp_state <= ALL_OFF;
                     lamp_pat   <= '0;
                  end else begin
                     lamp_pat <= lamp_pat << 1;
                  end
               end else begin
                  step_cnt <= step_cnt - STEP_W'(1);
               end
            end
            ALL_OFF: begin
               if (step_cnt == '0) begin
                  lamp_state       <= IDLE;
                  lamp_test_busy_o <= 1'b0;
               end else begin
                  step_cnt <= step_cnt - STEP_W'(1);
               end
            end
            default: begin
               lamp_state       <= IDLE;
               step_cnt         <= '0;
               lamp_pat         <= '0;
               lamp_test_busy_o <= 1'b0;
            end
         endcase
      end
   end

   // Output register. The lamp pattern bypasses the stretcher and the PWM,
   // and both keep running underneath, so normal display resumes cleanly.
   // Polarity is applied last and is not resynchronised.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         led_o <= '0;
      end else if (lamp_test_busy_o) begin
         led_o <= lamp_pat ^ {NLEDS{invert_i}};
      end else begin
         led_o <= (str & {NLEDS{pwm_on}}) ^ {NLEDS{invert_i}};
      end
   end

endmodule

// File: tb/tb_led_output_driver.sv
// ----------------------------------------------------------------------------
// tb_led_output_driver
//
// Directed testbench for led_output_driver. It uses short stretch and lamp
// step times so that every feature fits in a few hundred cycles.
// ----------------------------------------------------------------------------
module tb_led_output_driver;

   localparam int NLEDS = 16;

   logic              clock;
   logic              reset_n;
   logic [NLEDS-1:0]  led_i;
   logic              stretch_en_i;
   logic [3:0]        brightness_i;
   logic              lamp_test_i;
   logic              invert_i;
   logic              lamp_test_busy_o;
   logic [NLEDS-1:0]  led_o;

   int total = 0;
   int bad   = 0;
   int since_rst = 0;

   led_output_driver #(
      .NLEDS            (NLEDS),
      .STRETCH_CYCLES   (10),
      .PWM_BITS         (4),
      .LAMP_STEP_CYCLES (4)
   ) dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .led_i            (led_i),
      .stretch_en_i     (stretch_en_i),
      .brightness_i     (brightness_i),
      .lamp_test_i      (lamp_test_i),
      .invert_i         (invert_i),
      .lamp_test_busy_o (lamp_test_busy_o),
      .led_o            (led_o)
   );

   // 10 ns fabric clock.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // One clock edge. Inputs change and outputs are sampled 1 ns after it.
   // since_rst counts edges taken out of reset, which equals the PWM count.
   task automatic step();
      @(posedge clock);
      if (reset_n) since_rst++;
      else since_rst = 0;
      #1;
   endtask

   // Lamp-test pin pattern k edges after the start edge.
   // normal_pix is what the pins show once the test has finished.
   function automatic logic [NLEDS-1:0] lamp_expect(int k, logic [NLEDS-1:0] normal_pix);
      logic [NLEDS-1:0] one;
      one = 16'h0001;
      if (k >= 1 && k <= 4) return 16'hFFFF;
      if (k >= 5 && k <= 68) return one << ((k - 5) / 4);
      if (k >= 69 && k <= 72) return 16'h0000;
      return normal_pix;
   endfunction

   task automatic test_reset();
      reset_n = 1'b0; led_i = 16'hFFFF; stretch_en_i = 1'b0;
      brightness_i = 4'd15; lamp_test_i = 1'b0; invert_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         total++;
         if (led_o !== 16'h0000 || lamp_test_busy_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_hold cyc%0d: led_o=%h busy=%b want 0000/0", i, led_o, lamp_test_busy_o);
         end
      end
      reset_n = 1'b1;
      step();
      total++;
      if (led_o !== 16'h0000) begin
         bad++;
         $display("[TB] FAIL reset_latency1: led_o=%h want 0000", led_o);
      end
      step();
      total++;
      if (led_o !== 16'hFFFF) begin
         bad++;
         $display("[TB] FAIL reset_latency2: led_o=%h want ffff", led_o);
      end
   endtask

   task automatic test_stretch();
      int lit, first, lit_late;
      led_i = 16'h0000;
      repeat (3) step();
      stretch_en_i = 1'b1;
      repeat (3) step();
      total++;
      if (led_o !== 16'h0000) begin
         bad++;
         $display("[TB] FAIL stretch_idle: led_o=%h want 0000", led_o);
      end
      // Single pulse on channel 10.
      led_i = 16'h0400;
      step();
      led_i = 16'h0000;
      lit = 0; first = -1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (led_o[10]) begin
            lit++;
            if (first < 0) first = i;
         end
      end
      total++;
      if (lit !== 11) begin
         bad++;
         $display("[TB] FAIL stretch_single: lit=%0d want 11", lit);
      end
      total++;
      if (first !== 0) begin
         bad++;
         $display("[TB] FAIL stretch_rise: first=%0d want 0", first);
      end
      // Re-pulse 5 cycles after the first one restarts the full hold.
      led_i = 16'h0400;
      step();
      led_i = 16'h0000;
      lit = 0; lit_late = 0;
      for (int i = 0; i < 30; i++) begin
         led_i = (i == 4) ? 16'h0400 : 16'h0000;
         step();
         if (led_o[10]) begin
            lit++;
            if (i >= 5) lit_late++;
         end
      end
      led_i = 16'h0000;
      total++;
      if (lit !== 16) begin
         bad++;
         $display("[TB] FAIL stretch_repulse_total: lit=%0d want 16", lit);
      end
      total++;
      if (lit_late !== 11) begin
         bad++;
         $display("[TB] FAIL stretch_repulse_hold: lit=%0d want 11", lit_late);
      end
   endtask

   task automatic test_pwm();
      int lit, p;
      logic new_period, exp_on;
      stretch_en_i = 1'b0;
      led_i = 16'h0001;
      brightness_i = 4'd3;
      repeat (20) step();
      lit = 0;
      for (int i = 0; i < 32; i++) begin
         step();
         if (led_o[0]) lit++;
      end
      total++;
      if (lit !== 8) begin
         bad++;
         $display("[TB] FAIL pwm_duty3: lit=%0d of 32 want 8", lit);
      end
      // Move to PWM count 5 and raise the brightness mid-period.
      for (int n = 0; n < 16 && (since_rst % 16) != 5; n++) step();
      brightness_i = 4'd15;
      new_period = 1'b0;
      for (int i = 0; i < 26; i++) begin
         step();
         p = (since_rst + 15) % 16;
         if (p == 0) new_period = 1'b1;
         exp_on = new_period ? 1'b1 : (p <= 3);
         total++;
         if (led_o[0] !== exp_on) begin
            bad++;
            $display("[TB] FAIL pwm_change cyc%0d: led_o[0]=%b want %b", i, led_o[0], exp_on);
         end
      end
   endtask

   task automatic test_lamp();
      logic [NLEDS-1:0] exp_led;
      led_i = 16'h00F0;
      repeat (3) step();
      total++;
      if (led_o !== 16'h00F0 || lamp_test_busy_o !== 1'b0) begin
         bad++;
         $display("[TB] FAIL lamp_pre: led_o=%h busy=%b want 00f0/0", led_o, lamp_test_busy_o);
      end
      lamp_test_i = 1'b1;
      step();
      lamp_test_i = 1'b0;
      total++;
      if (lamp_test_busy_o !== 1'b1) begin
         bad++;
         $display("[TB] FAIL lamp_busy_rise: busy=%b want 1", lamp_test_busy_o);
      end
      for (int k = 1; k <= 80; k++) begin
         lamp_test_i = (k == 10);
         step();
         lamp_test_i = 1'b0;
         exp_led = lamp_expect(k, 16'h00F0);
         total++;
         if (lamp_test_busy_o !== (k <= 71)) begin
            bad++;
            $display("[TB] FAIL lamp_busy k=%0d: busy=%b want %b", k, lamp_test_busy_o, (k <= 71));
         end
         total++;
         if (led_o !== exp_led) begin
            bad++;
            $display("[TB] FAIL lamp_pattern k=%0d: led_o=%h want %h", k, led_o, exp_led);
         end
      end
   endtask

   task automatic test_abort();
      lamp_test_i = 1'b1;
      step();
      lamp_test_i = 1'b0;
      for (int k = 1; k <= 25; k++) step();
      total++;
      if (led_o !== 16'h0020 || lamp_test_busy_o !== 1'b1) begin
         bad++;
         $display("[TB] FAIL abort_sweep5: led_o=%h busy=%b want 0020/1", led_o, lamp_test_busy_o);
      end
      reset_n = 1'b0;
      step();
      total++;
      if (led_o !== 16'h0000 || lamp_test_busy_o !== 1'b0) begin
         bad++;
         $display("[TB] FAIL abort_reset: led_o=%h busy=%b want 0000/0", led_o, lamp_test_busy_o);
      end
      reset_n = 1'b1;
      step();
      step();
      total++;
      if (led_o !== 16'h00F0) begin
         bad++;
         $display("[TB] FAIL abort_resume: led_o=%h want 00f0", led_o);
      end
      lamp_test_i = 1'b1;
      step();
      lamp_test_i = 1'b0;
      total++;
      if (lamp_test_busy_o !== 1'b1) begin
         bad++;
         $display("[TB] FAIL abort_restart_busy: busy=%b want 1", lamp_test_busy_o);
      end
      step();
      total++;
      if (led_o !== 16'hFFFF) begin
         bad++;
         $display("[TB] FAIL abort_restart_allon: led_o=%h want ffff", led_o);
      end
      repeat (76) step();
      total++;
      if (lamp_test_busy_o !== 1'b0 || led_o !== 16'h00F0) begin
         bad++;
         $display("[TB] FAIL abort_done: led_o=%h busy=%b want 00f0/0", led_o, lamp_test_busy_o);
      end
   endtask

   task automatic test_invert();
      logic [NLEDS-1:0] exp_led;
      invert_i = 1'b1;
      step();
      total++;
      if (led_o !== 16'hFF0F) begin
         bad++;
         $display("[TB] FAIL invert_normal: led_o=%h want ff0f", led_o);
      end
      lamp_test_i = 1'b1;
      step();
      lamp_test_i = 1'b0;
      for (int k = 1; k <= 73; k++) begin
         step();
         if (k == 1 || k == 20 || k == 69 || k == 72 || k == 73) begin
            exp_led = lamp_expect(k, 16'h00F0) ^ 16'hFFFF;
            total++;
            if (led_o !== exp_led) begin
               bad++;
               $display("[TB] FAIL invert_lamp k=%0d: led_o=%h want %h", k, led_o, exp_led);
            end
         end
      end
      invert_i = 1'b0;
      step();
      total++;
      if (led_o !== 16'h00F0) begin
         bad++;
         $display("[TB] FAIL invert_off: led_o=%h want 00f0", led_o);
      end
   endtask

   // Scenarios run back to back. Each one leaves the inputs in a known state
   // for the next.
   initial begin
      test_reset();
      test_stretch();
      test_pwm();
      test_lamp();
      test_abort();
      test_invert();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
